fp_convert_scheduler: RTL and testbench
=======================================

FP_CONVERT_SCHEDULER -- requirements
Module: fp_convert_scheduler

Interface
REQ-001 SHALL have parameter LENGTH, default 8: FP32_8 elements per request vector.
REQ-002 SHALL have parameter LANES, default 2: converter lanes per beat; LENGTH SHALL be a multiple of LANES.
REQ-003 SHALL have parameter USE_REG, default 0: converter pipeline register; CONV_LAT = USE_REG ? 1 : 0 cycles.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req_valid_in, input, 2 bits: per-requester request valid.
REQ-007 SHALL have port req_data_in, input, 2 x FP32_8[LENGTH]: per-requester source vector.
REQ-008 SHALL have port req_ready_out, output, 2 bits: per-requester accept strobe.
REQ-009 SHALL have port resp_valid_out, output, 1 bit: converted vector available.
REQ-010 SHALL have port resp_id_out, output, 1 bit: index of the requester owning the response.
REQ-011 SHALL have port resp_data_out, output, FP16_5[LENGTH]: converted vector.
REQ-012 SHALL have port resp_ready_in, input, 1 bit: response consumer ready.
REQ-013 SHALL have port debugen_in, input, 1 bit: enables per-beat $write trace.

Function
REQ-014 SHALL implement FSM states IDLE, CONV, DRAIN and RESP.
REQ-015 In IDLE, SHALL grant round-robin: if only one req_valid_in bit is set, grant it; if both are set, grant the requester not granted last.
REQ-016 req_ready_out[g] SHALL be 1 only in IDLE, for the granted g, while req_valid_in[g] is 1; all other req_ready_out bits SHALL be 0.
REQ-017 On accept (valid & ready), SHALL latch req_data_in[g] into an input buffer, record g as owner, clear the beat counter, and go to CONV.
REQ-018 In CONV, beat k (0..BEATS-1, BEATS = LENGTH/LANES) SHALL drive source elements k*LANES..k*LANES+LANES-1 to the converter, one beat per cycle.
REQ-019 Converter result of beat k SHALL be written to result-buffer elements k*LANES.. exactly CONV_LAT cycles after issue.
REQ-020 After the last beat, SHALL go to DRAIN if CONV_LAT = 1, else go directly to RESP; DRAIN SHALL last one cycle.
REQ-021 Timing: accept at cycle A SHALL give resp_valid_out = 1 first at cycle A + BEATS + CONV_LAT + 1.
REQ-022 In RESP, resp_valid_out = 1, resp_id_out = owner and resp_data_out = result buffer; these SHALL be stable until resp_valid_out & resp_ready_in.
REQ-023 On the response handshake, SHALL return to IDLE, with a new accept possible the next cycle; no accept SHALL occur in CONV, DRAIN or RESP.
REQ-024 Conversion per element SHALL match FpConverterFP32_8_FP16_5 bit-exactly:
  - sign copied
  - exponent rebiased 127 -> 15
  - exp = 255 or unbiased > 16 -> 31
  - exp = 0 or unbiased <= -16 -> 0
  - mantissa truncated (>> 13), no rounding.
REQ-025 Input changes after accept SHALL NOT affect the in-flight result.
REQ-026 When debugen_in = 1, SHALL print beat index, owner and lane data each CONV cycle.

Reset
REQ-027 Reset SHALL force IDLE; resp_valid_out = 0, req_ready_out = 0, resp_id_out = 0, last-grant = 1 (requester 0 wins first tie), beat counter = 0.
REQ-028 Reset asserted mid-CONV/DRAIN/RESP SHALL abort the transaction with no response issued; buffer contents SHALL be don't-care.

Structure
REQ-029 FP32_8 and FP16_5 SHALL come from FP32_8_pkg and FP16_5_pkg; the FSM state enum SHALL live in a shared FpSched_pkg.
REQ-030 SHALL instantiate exactly one FpConverterFP32_8_FP16_5 with LENGTH = LANES and USE_REG passed through.

Verification
REQ-031 LENGTH=8, LANES=2, USE_REG=0: req0 all elements 0x3F800000 -> resp at A+5, id 0, all 0x3C00.
REQ-032 Mixed values 0xC0000000, 0x7F800000, 0x00000000, 0x7F000000 -> 0xC000, 0x7C00, 0x0000, 0x7C00 in the matching positions.
REQ-033 Both requesters valid from reset -> req0 served first, then req1; alternation continues while both remain valid.
REQ-034 USE_REG=1 -> resp at A+6; resp_ready_in held low 3 cycles -> data and id stable, no new accept.
REQ-035 Reset pulsed during CONV beat 2 -> no response; next request completes with correct data.

Source files
------------

// File: rtl/FP16_5_pkg.sv
// FP16_5 result format: IEEE-754 half precision layout
// (1 sign bit, 5 exponent bits, 10 mantissa bits).
package FP16_5_pkg;

  localparam int FP16_5_EXP_W   = 5;
  localparam int FP16_5_MANT_W  = 10;
  localparam int FP16_5_BIAS    = 15;
  localparam int FP16_5_EXP_MAX = 31;

  typedef struct packed {
    logic                      sign;
    logic [FP16_5_EXP_W-1:0]   expo;
    logic [FP16_5_MANT_W-1:0]  mant;
  } FP16_5;

endpackage

// File: rtl/FP32_8_pkg.sv
// FP32_8 source format: IEEE-754 single precision layout
// (1 sign bit, 8 exponent bits, 23 mantissa bits).
package FP32_8_pkg;

  localparam int FP32_8_EXP_W  = 8;
  localparam int FP32_8_MANT_W = 23;
  localparam int FP32_8_BIAS   = 127;
  localparam int FP32_8_EXP_MAX = 255;

  typedef struct packed {
    logic                      sign;
    logic [FP32_8_EXP_W-1:0]   expo;
    logic [FP32_8_MANT_W-1:0]  mant;
  } FP32_8;

endpackage

// File: rtl/FpSched_pkg.sv
// Shared scheduler state encoding for the FP conversion scheduler.
package FpSched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } fp_sched_state_e;

endpackage

// File: rtl/FpConverterFP32_8_FP16_5.sv
// Element-wise FP32_8 -> FP16_5 converter.
//   clk      : clock for the optional output register
//   data_in  : LENGTH source elements
//   data_out : LENGTH converted elements, 0 or 1 cycle after data_in
//              depending on USE_REG
// Conversion: sign copied, exponent rebiased 127 -> 15 and saturated to
// 31 on overflow/Inf/NaN, flushed to 0 on underflow/zero/denormal,
// mantissa truncated to its top 10 bits.
module FpConverterFP32_8_FP16_5
  import FP32_8_pkg::*;
  import FP16_5_pkg::*;
#(
  parameter int LENGTH  = 1,
  parameter int USE_REG = 0
) (
  input  logic  clk,
  input  FP32_8 data_in  [LENGTH],
  output FP16_5 data_out [LENGTH]
);

  // Source exponents above OVF_EXP have unbiased value > 16; those at or
  // below UNF_EXP have unbiased value <= -16.
  localparam int OVF_EXP = FP32_8_BIAS + FP16_5_EXP_MAX - FP16_5_BIAS;
  localparam int UNF_EXP = FP32_8_BIAS - FP16_5_BIAS - 1;
  localparam int REBIAS  = FP32_8_BIAS - FP16_5_BIAS;

  function automatic FP16_5 cvt(input FP32_8 a);
    FP16_5 r;
    r.sign = a.sign;
    r.mant = a.mant[FP32_8_MANT_W-1 -: FP16_5_MANT_W];
    if (a.expo == FP32_8_EXP_W'(FP32_8_EXP_MAX) || a.expo > FP32_8_EXP_W'(OVF_EXP))
      r.expo = FP16_5_EXP_W'(FP16_5_EXP_MAX);
    else if (a.expo <= FP32_8_EXP_W'(UNF_EXP))
      r.expo = '0;
    else
      r.expo = FP16_5_EXP_W'(a.expo - FP32_8_EXP_W'(REBIAS));
    return r;
  endfunction

  FP16_5 conv [LENGTH];

  always_comb begin
    for (int unsigned i = 0; i < LENGTH; i++)
      conv[i] = cvt(data_in[i]);
  end

  if (USE_REG != 0) begin : g_reg
    always_ff @(posedge clk) data_out <= conv;
  end else begin : g_comb
    always_comb data_out = conv;
  end

endmodule

// File: rtl/fp_convert_scheduler.sv
// Two-requester FP32_8 -> FP16_5 vector conversion scheduler.
//   clk, reset      : clock, synchronous active-high reset
//   req_valid_in    : per-requester request valid
//   req_data_in     : per-requester LENGTH-element source vectors
//   req_ready_out   : per-requester accept strobe (IDLE only, granted one)
//   resp_valid_out  : converted vector available
//   resp_id_out     : requester owning the response
//   resp_data_out   : converted LENGTH-element vector
//   resp_ready_in   : response consumer ready
//   debugen_in      : per-beat trace enable
// An accepted vector is buffered, pushed through a LANES-wide converter
// one beat per cycle, collected in a result buffer and then held as the
// response until the consumer takes it.
module fp_convert_scheduler
  import FP32_8_pkg::*;
  import FP16_5_pkg::*;
  import FpSched_pkg::*;
#(
  parameter int LENGTH  = 8,
  parameter int LANES   = 2,
  parameter int USE_REG = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid_in,
  input  FP32_8       req_data_in [2][LENGTH],
  output logic [1:0]  req_ready_out,
  output logic        resp_valid_out,
  output logic        resp_id_out,
  output FP16_5       resp_data_out [LENGTH],
  input  logic        resp_ready_in,
  input  logic        debugen_in
);

  localparam int BEATS    = LENGTH / LANES;
  localparam int CONV_LAT = (USE_REG != 0) ? 1 : 0;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W    = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  fp_sched_state_e   state;
  logic [BEAT_W-1:0] beat;
  logic              owner;
  logic              last_grant;
  logic              grant;
  logic              accept;

  FP32_8 src_buf  [LENGTH];
  FP16_5 res_buf  [LENGTH];
  FP32_8 lane_in  [LANES];
  FP16_5 lane_out [LANES];

  logic              wr_en_q;
  logic [BEAT_W-1:0] wr_beat_q;
  logic              wr_en;
  logic [BEAT_W-1:0] wr_beat;

  // Round-robin: a lone requester wins outright, a tie goes to the one
  // not granted last time.
  always_comb begin
    grant = 1'b0;
    if (req_valid_in == 2'b11)
      grant = ~last_grant;
    else if (req_valid_in[1])
      grant = 1'b1;
    req_ready_out = '0;
    if (state == IDLE)
      req_ready_out[grant] = req_valid_in[grant];
  end

  assign accept = |(req_valid_in & req_ready_out);

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++)
      lane_in[l] = src_buf[IDX_W'(beat * LANES + l)];
  end

  FpConverterFP32_8_FP16_5 #(
    .LENGTH  (LANES),
    .USE_REG (USE_REG)
  ) u_conv (
    .clk      (clk),
    .data_in  (lane_in),
    .data_out (lane_out)
  );

  // With the converter register enabled the write-back trails issue by one
  // cycle, so the issuing beat index is carried alongside.
  assign wr_en   = (CONV_LAT != 0) ? wr_en_q   : (state == CONV);
  assign wr_beat = (CONV_LAT != 0) ? wr_beat_q : beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      beat           <= '0;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      resp_valid_out <= 1'b0;
      resp_id_out    <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_beat_q      <= '0;
    end else begin
      wr_en_q   <= (state == CONV);
      wr_beat_q <= beat;
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            beat       <= '0;
            state      <= CONV;
          end
        end
        CONV: begin
          if (beat == BEAT_W'(BEATS - 1)) begin
            beat <= '0;
            if (CONV_LAT != 0) begin
              state <= DRAIN;
            end else begin
              state          <= RESP;
              resp_valid_out <= 1'b1;
              resp_id_out    <= owner;
            end
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DRAIN: begin
          state          <= RESP;
          resp_valid_out <= 1'b1;
          resp_id_out    <= owner;
        end
        RESP: begin
          if (resp_ready_in) begin
            resp_valid_out <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data buffers carry no reset: their contents are meaningless outside
  // an in-flight transaction.
  always_ff @(posedge clk) begin
    if (accept)
      src_buf <= req_data_in[grant];
    if (wr_en) begin
      for (int unsigned l = 0; l < LANES; l++)
        res_buf[IDX_W'(wr_beat * LANES + l)] <= lane_out[l];
    end
  end

  always_comb resp_data_out = res_buf;

  always_ff @(posedge clk) begin
    if (!reset && debugen_in && state == CONV) begin
      $write("fp_sched beat=%0d owner=%0d", beat, owner);
      for (int unsigned l = 0; l < LANES; l++)
        $write(" lane%0d=%08h", l, lane_in[l]);
      $write("\n");
    end
  end

endmodule

// File: tb/tb_fp_convert_scheduler.sv
module tb_fp_convert_scheduler;
  import FP32_8_pkg::*;
  import FP16_5_pkg::*;

  localparam int LENGTH = 8;
  localparam int LANES  = 2;
  localparam int BEATS  = LENGTH / LANES;

  logic clk = 1'b0;
  logic reset;
  logic debugen;
  logic sel;
  logic [1:0] valid_a, valid_b;
  logic ready_in_a, ready_in_b;
  FP32_8 data [2][LENGTH];

  logic [1:0] rdy_a, rdy_b;
  logic rv_a, rv_b, rid_a, rid_b;
  FP16_5 rd_a [LENGTH];
  FP16_5 rd_b [LENGTH];

  logic [1:0] o_rdy;
  logic o_rv, o_rid;
  logic [16*LENGTH-1:0] o_rd_flat;

  int checks = 0;
  int failures = 0;
  logic last_g [2];

  always #5 clk = ~clk;

  fp_convert_scheduler #(.LENGTH(LENGTH), .LANES(LANES), .USE_REG(0)) dut_a (
    .clk(clk), .reset(reset), .req_valid_in(valid_a), .req_data_in(data),
    .req_ready_out(rdy_a), .resp_valid_out(rv_a), .resp_id_out(rid_a),
    .resp_data_out(rd_a), .resp_ready_in(ready_in_a), .debugen_in(debugen)
  );

  fp_convert_scheduler #(.LENGTH(LENGTH), .LANES(LANES), .USE_REG(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid_in(valid_b), .req_data_in(data),
    .req_ready_out(rdy_b), .resp_valid_out(rv_b), .resp_id_out(rid_b),
    .resp_data_out(rd_b), .resp_ready_in(ready_in_b), .debugen_in(1'b0)
  );

  always_comb begin
    o_rdy = sel ? rdy_b : rdy_a;
    o_rv  = sel ? rv_b  : rv_a;
    o_rid = sel ? rid_b : rid_a;
    o_rd_flat = '0;
    for (int i = 0; i < LENGTH; i++)
      o_rd_flat[i*16 +: 16] = sel ? rd_b[i] : rd_a[i];
  end

  // Reference conversion written from the format rules directly.
  function automatic logic [15:0] ref_cvt(input logic [31:0] x);
    int e, ue, ne;
    e  = int'(x[30:23]);
    ue = e - 127;
    if (e == 255 || ue > 16)       ne = 31;
    else if (e == 0 || ue <= -16)  ne = 0;
    else                           ne = ue + 15;
    return {x[31], 5'(ne), x[22:13]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int e;
    v = $urandom();
    case ($urandom_range(0, 5))
      0: e = 0;
      1: e = 255;
      2: e = $urandom_range(105, 150);
      default: e = $urandom_range(0, 255);
    endcase
    v[30:23] = 8'(e);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic [1:0] v);
    if (sel) valid_b = v; else valid_a = v;
  endtask

  task automatic set_ready(input logic r);
    if (sel) ready_in_b = r; else ready_in_a = r;
  endtask

  task automatic randomize_data();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < LENGTH; i++)
        data[r][i] = rand_fp();
  endtask

  task automatic do_reset();
    valid_a = '0; valid_b = '0; ready_in_a = 1'b0; ready_in_b = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    last_g[0] = 1'b1;
    last_g[1] = 1'b1;
    #1;
    chk("reset_valid_a", rv_a, 1'b0);
    chk("reset_id_a", rid_a, 1'b0);
    chk("reset_ready_a", rdy_a, 2'b00);
    chk("reset_valid_b", rv_b, 1'b0);
    chk("reset_id_b", rid_b, 1'b0);
  endtask

  // Called at posedge+1 with the selected DUT idle. Returns at posedge+2
  // of the first cycle back in IDLE.
  task automatic txn(input logic [1:0] vmask, input int lat, input int hold, input bit keep);
    logic [16*LENGTH-1:0] exp_flat;
    logic owner;
    int cyc;
    owner = (vmask == 2'b11) ? ~last_g[sel] : vmask[1];
    last_g[sel] = owner;
    set_valid(vmask);
    #1;
    chk("grant", o_rdy, 2'b01 << owner);
    for (int i = 0; i < LENGTH; i++)
      exp_flat[i*16 +: 16] = ref_cvt(data[owner][i]);
    step();
    if (!keep) set_valid(2'b00);
    randomize_data();
    #1;
    cyc = 1;
    while (o_rv !== 1'b1 && cyc < 20) begin
      chk("busy_no_ready", o_rdy, 2'b00);
      step(); #1;
      cyc++;
    end
    chk("latency", cyc, BEATS + lat + 1);
    chk("resp_id", o_rid, owner);
    for (int i = 0; i < LENGTH; i++)
      chk("resp_elem", o_rd_flat[i*16 +: 16], exp_flat[i*16 +: 16]);
    for (int h = 0; h < hold; h++) begin
      step(); #1;
      chk("hold_valid", o_rv, 1'b1);
      chk("hold_id", o_rid, owner);
      chk("hold_data", o_rd_flat, exp_flat);
      chk("hold_no_ready", o_rdy, 2'b00);
    end
    set_ready(1'b1);
    step();
    set_ready(1'b0);
    #1;
    chk("resp_done", o_rv, 1'b0);
  endtask

  initial begin
    sel = 1'b0;
    debugen = 1'b0;
    randomize_data();
    do_reset();
    step();

    // all-ones vector on requester 0, with trace enabled
    for (int i = 0; i < LENGTH; i++) data[0][i] = 32'h3F80_0000;
    debugen = 1'b1;
    txn(2'b01, 0, 0, 1'b0);
    debugen = 1'b0;
    step();

    // mixed special values on requester 1
    begin
      logic [31:0] mix [4];
      mix[0] = 32'hC000_0000; mix[1] = 32'h7F80_0000;
      mix[2] = 32'h0000_0000; mix[3] = 32'h7F00_0000;
      for (int i = 0; i < LENGTH; i++) data[1][i] = mix[i % 4];
    end
    txn(2'b10, 0, 0, 1'b0);
    step();

    // both valid from reset: alternation while both stay valid
    do_reset();
    step();
    randomize_data();
    set_valid(2'b11);
    txn(2'b11, 0, 0, 1'b1);
    txn(2'b11, 0, 0, 1'b1);
    txn(2'b11, 0, 0, 1'b1);
    txn(2'b11, 0, 1, 1'b0);
    step();

    // reset during beat 2 aborts; next request still correct
    randomize_data();
    set_valid(2'b01);
    step();
    set_valid(2'b00);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_g[0] = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("abort_no_resp", rv_a, 1'b0);
      step(); #1;
    end
    txn(2'b01, 0, 0, 1'b0);
    step();

    // random traffic on the combinational-converter instance
    for (int t = 0; t < 6; t++) begin
      logic [1:0] vm;
      vm = 2'($urandom_range(1, 3));
      randomize_data();
      txn(vm, 0, $urandom_range(0, 2), 1'b0);
      step();
    end

    // registered-converter instance: extra latency and held response
    sel = 1'b1;
    randomize_data();
    txn(2'b01, 1, 3, 1'b1);
    set_valid(2'b00);
    step();
    for (int t = 0; t < 5; t++) begin
      logic [1:0] vm;
      vm = 2'($urandom_range(1, 3));
      randomize_data();
      txn(vm, 1, $urandom_range(0, 3), 1'b0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
